// File: rtl/w5300_socket_n_tcp_client_conf.sv
// rtl/w5300_socket_n_tcp_client_conf.sv - W5300 socket TCP client bring-up, link monitor and retry sequencer
module w5300_socket_n_tcp_client_conf #(
    parameter int          SOCKET_N     = 0,
    parameter logic [15:0] LOCAL_PORT   = 16'd5000,
    parameter logic [31:0] DEST_IP      = 32'hC0A8_0164,
    parameter logic [15:0] DEST_PORT    = 16'd5001,
    parameter int          INIT_TIMEOUT = 128,
    parameter int          CONN_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        op_state,
    input  logic [15:0] rd_data,
    output logic        done,
    output logic [10:0] addr,
    output logic [15:0] wr_data
);

    localparam logic [9:0]  BASE       = 10'(32'h200 + SOCKET_N * 32'h40);
    localparam logic [15:0] MR_TCP     = 16'h0001;
    localparam logic [15:0] CR_OPEN    = 16'h0001;
    localparam logic [15:0] CR_CONNECT = 16'h0004;
    localparam logic [15:0] CR_CLOSE   = 16'h0010;
    localparam logic [7:0]  SSR_INIT   = 8'h13;
    localparam logic [7:0]  SSR_EST    = 8'h17;
    localparam logic [15:0] INIT_LAST  = 16'(INIT_TIMEOUT - 1);
    localparam logic [15:0] CONN_LAST  = 16'(CONN_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, WR_MR, WR_PORT, WR_DIP0, WR_DIP1, WR_DPORT, CMD_OPEN,
        POLL_INIT, CMD_CONNECT, POLL_EST, LINKED, CMD_CLOSE
    } state_t;

    state_t      state;
    state_t      nxt;
    logic        active;     // access of the current state is on the bus
    logic [15:0] tcnt;
    logic        acc_wr;
    logic [9:0]  acc_off;
    logic [15:0] acc_data;
    logic        is_poll;
    logic        tmo;
    logic [7:0]  status;

    assign status = rd_data[7:0];

    // Decode the bus access each state issues and its normal successor
    always_comb begin
        acc_wr   = 1'b1;
        acc_off  = 10'h002;
        acc_data = 16'h0000;
        nxt      = state;
        case (state)
            WR_MR:       begin acc_off = 10'h000; acc_data = MR_TCP;         nxt = WR_PORT;     end
            WR_PORT:     begin acc_off = 10'h00A; acc_data = LOCAL_PORT;     nxt = WR_DIP0;     end
            WR_DIP0:     begin acc_off = 10'h014; acc_data = DEST_IP[31:16]; nxt = WR_DIP1;     end
            WR_DIP1:     begin acc_off = 10'h016; acc_data = DEST_IP[15:0];  nxt = WR_DPORT;    end
            WR_DPORT:    begin acc_off = 10'h012; acc_data = DEST_PORT;      nxt = CMD_OPEN;    end
            CMD_OPEN:    begin acc_data = CR_OPEN;                           nxt = POLL_INIT;   end
            POLL_INIT:   begin acc_wr = 1'b0; acc_off = 10'h008;             nxt = CMD_CONNECT; end
            CMD_CONNECT: begin acc_data = CR_CONNECT;                        nxt = POLL_EST;    end
            POLL_EST:    begin acc_wr = 1'b0; acc_off = 10'h008;             nxt = LINKED;      end
            LINKED:      begin acc_wr = 1'b0; acc_off = 10'h008;             nxt = LINKED;      end
            CMD_CLOSE:   begin acc_data = CR_CLOSE;                          nxt = IDLE;        end
            default:     begin acc_wr = 1'b0; acc_off = 10'h000;             nxt = IDLE;        end
        endcase
        is_poll = (state == POLL_INIT) || (state == POLL_EST);
        tmo     = (state == POLL_INIT) ? (tcnt >= INIT_LAST) : (tcnt >= CONN_LAST);
    end

    // Sequencer: present an access, complete it on op_state, then pick the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            active  <= 1'b0;
            tcnt    <= 16'h0000;
            addr    <= 11'h000;
            wr_data <= 16'h0000;
            done    <= 1'b0;
        end else begin
            // Non-poll states hold the counter at zero, so each poll starts from zero
            tcnt <= is_poll ? (tmo ? tcnt : tcnt + 16'h0001) : 16'h0000;
            if (state == IDLE) begin
                addr    <= 11'h000;
                wr_data <= 16'h0000;
                done    <= 1'b0;
                active  <= 1'b0;
                if (enable) state <= WR_MR;
            end else if (!active) begin
                if (!enable && state != CMD_CLOSE) begin
                    state <= CMD_CLOSE;
                    done  <= 1'b0;
                end else if (is_poll && tmo) begin
                    state <= CMD_CLOSE;
                end else begin
                    addr    <= {acc_wr, BASE + acc_off};
                    wr_data <= acc_wr ? acc_data : 16'h0000;
                    active  <= 1'b1;
                end
            end else if (op_state) begin
                active  <= 1'b0;
                addr    <= 11'h000;
                wr_data <= 16'h0000;
                if (state == CMD_CLOSE) begin
                    state <= IDLE;
                end else if (!enable) begin
                    state <= CMD_CLOSE;
                    done  <= 1'b0;
                end else if (state == POLL_INIT) begin
                    // A match in the same cycle as the timeout takes priority
                    if (status == SSR_INIT) state <= CMD_CONNECT;
                    else if (tmo)           state <= CMD_CLOSE;
                end else if (state == POLL_EST) begin
                    if (status == SSR_EST) begin
                        state <= LINKED;
                        done  <= 1'b1;
                    end else if (tmo) begin
                        state <= CMD_CLOSE;
                    end
                end else if (state == LINKED) begin
                    if (status != SSR_EST) begin
                        state <= CMD_CLOSE;
                        done  <= 1'b0;
                    end
                end else begin
                    state <= nxt;
                end
            end
        end
    end

endmodule
